// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between the instruction-fetch
// requester (i_*) and the load/store requester (d_*) of the rv32i core.
// A registered FSM grants one side at a time. When both sides request in the
// same cycle, the side that was not granted last time wins (round-robin).
// The granted side's request is forwarded combinationally to mem_*.
// mem_resp is routed back to the granted side only.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   i_read, i_addr       instruction read request (held until i_resp)
//   i_rdata, i_resp      instruction read data / one-cycle completion
//   d_read, d_write      data-side read / write request
//   d_addr, d_wdata      data-side address / store data
//   d_byte_enable        data-side byte mask
//   d_rdata, d_resp      data read data / one-cycle completion
//   mem_read, mem_write  memory strobes
//   mem_addr, mem_wdata  memory address / write data
//   mem_byte_enable      memory byte mask
//   mem_rdata, mem_resp  memory read data / completion pulse
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_read,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_resp,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_byte_enable,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_resp,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_resp
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_I = 2'b01,
    GRANT_D = 2'b10
  } state_t;

  state_t state_q, state_d;
  // 0 = instruction side granted last, 1 = data side granted last
  logic   last_grant_q, last_grant_d;

  logic i_req_s;
  logic d_req_s;

  assign i_req_s = i_read;
  assign d_req_s = d_read | d_write;

  // Read data is shared; consumers qualify it with their own resp.
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // State and round-robin history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next-state selection, memory port mux and response routing
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_addr        = {ADDR_WIDTH{1'b0}};
    mem_wdata       = {DATA_WIDTH{1'b0}};
    mem_byte_enable = {BE_WIDTH{1'b0}};
    i_resp          = 1'b0;
    d_resp          = 1'b0;

    case (state_q)
      IDLE: begin
        // A stray mem_resp here is ignored: no resp output is driven.
        if (i_req_s && d_req_s) begin
          // Tie: grant the side opposite the previous grant.
          if (last_grant_q) begin
            state_d      = GRANT_I;
            last_grant_d = 1'b0;
          end else begin
            state_d      = GRANT_D;
            last_grant_d = 1'b1;
          end
        end else if (i_req_s) begin
          state_d      = GRANT_I;
          last_grant_d = 1'b0;
        end else if (d_req_s) begin
          state_d      = GRANT_D;
          last_grant_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      GRANT_I: begin
        mem_read        = i_read;
        mem_addr        = i_addr;
        mem_byte_enable = {BE_WIDTH{1'b1}};
        i_resp          = mem_resp;
        // Completion or abort both return to IDLE; an abort gives no resp.
        if (mem_resp || !i_req_s) begin
          state_d = IDLE;
        end else begin
          state_d = GRANT_I;
        end
      end

      GRANT_D: begin
        // Write wins when both strobes are up; no read is issued then.
        mem_read        = d_read & ~d_write;
        mem_write       = d_write;
        mem_addr        = d_addr;
        mem_wdata       = d_wdata;
        mem_byte_enable = d_byte_enable;
        d_resp          = mem_resp;
        if (mem_resp || !d_req_s) begin
          state_d = IDLE;
        end else begin
          state_d = GRANT_D;
        end
      end

      default: begin
        state_d      = IDLE;
        last_grant_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        i_read;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byte_enable;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    logic [31:0] mrd;
    logic        mresp;
    logic        e_mr;
    logic        e_mw;
    logic [31:0] e_ma;
    logic [31:0] e_mwd;
    logic [3:0]  e_mbe;
    logic        e_ir;
    logic        e_dr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw,
                              logic [31:0] da, logic [31:0] dwd, logic [3:0] dbe,
                              logic [31:0] mrd, logic mresp,
                              logic e_mr, logic e_mw, logic [31:0] e_ma,
                              logic [31:0] e_mwd, logic [3:0] e_mbe,
                              logic e_ir, logic e_dr);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.dbe = dbe; v.mrd = mrd; v.mresp = mresp;
    v.e_mr = e_mr; v.e_mw = e_mw; v.e_ma = e_ma; v.e_mwd = e_mwd;
    v.e_mbe = e_mbe; v.e_ir = e_ir; v.e_dr = e_dr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_read = 1'b0; i_addr = 32'h0;
    d_read = 1'b0; d_write = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    d_byte_enable = 4'h0; mem_rdata = 32'h0; mem_resp = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // ---------------- reset state, with a request held during reset
    @(negedge clk);
    i_read = 1'b1; i_addr = 32'h44; d_read = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("reset mem_read", {63'd0, mem_read}, 64'd0);
    chk("reset mem_write", {63'd0, mem_write}, 64'd0);
    chk("reset i_resp", {63'd0, i_resp}, 64'd0);
    chk("reset d_resp", {63'd0, d_resp}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #2;
    chk("post-reset mem_addr", {32'd0, mem_addr}, 64'd0);
    chk("post-reset mem_byte_enable", {60'd0, mem_byte_enable}, 64'd0);

    // ---------------- directed vector table (one row per cycle)
    // single instruction read, memory answers 2 cycles after strobe
    vecs.push_back(mk(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 4'hF, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 4'hF, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h13, 1'b1, 1'b1, 1'b0, 32'h60, 32'h0, 4'hF, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h13, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0));
    // data write with partial byte mask
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3, 32'h0, 1'b0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3, 32'hCAFE, 1'b1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 4'h3, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0));
    // simultaneous: instruction first, data after the IDLE cycle
    vecs.push_back(mk(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h5A5A, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h200, 1'b1, 1'b0, 32'h300, 32'h5A5A, 4'hF, 32'hAAAA, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 4'hF, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h5A5A, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h5A5A, 4'hF, 32'h5555, 1'b1, 1'b1, 1'b0, 32'h300, 32'h5A5A, 4'hF, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0));
    // read and write together: write only
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'hC, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h12345678, 4'hC, 32'h77, 1'b1, 1'b0, 1'b1, 32'h40, 32'h12345678, 4'hC, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0));
    // abort in GRANT_D, then a stray resp in IDLE
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h80, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h0, 4'hF, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h99, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1111, 1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0));

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      i_read = vecs[k].ir; i_addr = vecs[k].ia;
      d_read = vecs[k].dr; d_write = vecs[k].dw; d_addr = vecs[k].da;
      d_wdata = vecs[k].dwd; d_byte_enable = vecs[k].dbe;
      mem_rdata = vecs[k].mrd; mem_resp = vecs[k].mresp;
      #2;
      chk($sformatf("v%0d mem_read", k), {63'd0, mem_read}, {63'd0, vecs[k].e_mr});
      chk($sformatf("v%0d mem_write", k), {63'd0, mem_write}, {63'd0, vecs[k].e_mw});
      chk($sformatf("v%0d mem_addr", k), {32'd0, mem_addr}, {32'd0, vecs[k].e_ma});
      chk($sformatf("v%0d mem_wdata", k), {32'd0, mem_wdata}, {32'd0, vecs[k].e_mwd});
      chk($sformatf("v%0d mem_byte_enable", k), {60'd0, mem_byte_enable}, {60'd0, vecs[k].e_mbe});
      chk($sformatf("v%0d i_resp", k), {63'd0, i_resp}, {63'd0, vecs[k].e_ir});
      chk($sformatf("v%0d d_resp", k), {63'd0, d_resp}, {63'd0, vecs[k].e_dr});
      if (vecs[k].e_ir) chk($sformatf("v%0d i_rdata", k), {32'd0, i_rdata}, {32'd0, vecs[k].mrd});
      if (vecs[k].e_dr) chk($sformatf("v%0d d_rdata", k), {32'd0, d_rdata}, {32'd0, vecs[k].mrd});
    end

    // ---------------- reset mid-transaction in GRANT_D
    do_reset();
    @(negedge clk);
    d_write = 1'b1; d_addr = 32'h500; d_wdata = 32'h1; d_byte_enable = 4'hF;
    @(negedge clk);
    #2;
    chk("midrst granted write", {63'd0, mem_write}, 64'd1);
    @(negedge clk);
    rst = 1'b1; i_read = 1'b1; i_addr = 32'h600;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("midrst mem_write dropped", {63'd0, mem_write}, 64'd0);
    chk("midrst mem_read dropped", {63'd0, mem_read}, 64'd0);
    @(negedge clk);
    #2;
    chk("midrst tie grants I", {63'd0, mem_read}, 64'd1);
    chk("midrst tie mem_addr", {32'd0, mem_addr}, {32'd0, 32'h600});
    chk("midrst tie no write", {63'd0, mem_write}, 64'd0);

    // ---------------- continuous contention: expect I,D,I,D,...
    begin
      int  served;
      int  cyc;
      int  age;
      bit  i_drop;
      bit  d_drop;
      bit  prev_resp;
      logic [31:0] exp_addr;
      served = 0; cyc = 0; age = 0;
      i_drop = 1'b0; d_drop = 1'b0; prev_resp = 1'b0;
      do_reset();
      i_addr = 32'h1000; d_addr = 32'h2000; d_byte_enable = 4'hF;
      while (served < 8 && cyc < 200) begin
        @(negedge clk);
        cyc++;
        mem_resp = 1'b0;
        i_read = ~i_drop;
        d_read = ~d_drop;
        i_drop = 1'b0;
        d_drop = 1'b0;
        #1;
        if (prev_resp) chk("contention idle gap", {63'd0, mem_read}, 64'd0);
        prev_resp = 1'b0;
        if (mem_read && age == 1) begin
          mem_resp = 1'b1;
          mem_rdata = 32'h100 + served;
          #1;
          exp_addr = (served % 2 == 0) ? 32'h1000 : 32'h2000;
          chk($sformatf("contention grant %0d addr", served), {32'd0, mem_addr}, {32'd0, exp_addr});
          if (served % 2 == 0) begin
            chk($sformatf("contention grant %0d i_resp", served), {63'd0, i_resp}, 64'd1);
            i_drop = 1'b1;
          end else begin
            chk($sformatf("contention grant %0d d_resp", served), {63'd0, d_resp}, 64'd1);
            d_drop = 1'b1;
          end
          served++;
          age = 0;
          prev_resp = 1'b1;
        end else if (mem_read) begin
          age++;
        end else begin
          age = 0;
        end
      end
      chk("contention completed 8 grants", 64'(served), 64'd8);
    end

    @(negedge clk);
    idle_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
